// File: rtl/g11620_pkg.sv
// Shared definitions for the G11620 frame sequencer: register map, CTRL bits,
// sequencer state encoding and CTRL word helpers.
package g11620_pkg;

  localparam logic [3:0] ADDR_CTRL  = 4'd0;
  localparam logic [3:0] ADDR_INTEG = 4'd1;

  localparam int CTRL_START_BIT = 31;
  localparam int CTRL_DONE_BIT  = 30;
  localparam int CTRL_SRST_BIT  = 29;

  localparam logic [31:0] CTRL_SRST_WORD = 32'h1 << CTRL_SRST_BIT;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_GAP,
    S_POLL,
    S_PWAIT,
    S_CLEAR,
    S_NEXT,
    S_ABORT,
    S_ABCLR
  } seq_state_t;

  // Acknowledge a finished frame: keep all other CTRL fields, drop start/done.
  function automatic logic [31:0] ctrl_ack(input logic [31:0] word);
    logic [31:0] res;
    res = word;
    res[CTRL_START_BIT] = 1'b0;
    res[CTRL_DONE_BIT]  = 1'b0;
    return res;
  endfunction

endpackage

// File: rtl/g11620_bus_arb.sv
// Register-port arbiter: the sequencer owns the bus when it asks for it, the host
// is passed through otherwise; a one-bit owner flag routes read returns.
module g11620_bus_arb
  import g11620_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        seq_own,
  input  logic        seq_wr,
  input  logic        seq_rd,
  input  logic [3:0]  seq_addr,
  input  logic [31:0] seq_data,
  input  logic        host_wr_in,
  input  logic        host_rd_in,
  input  logic [3:0]  host_addr_in,
  input  logic [31:0] host_data_in,
  output logic        host_ready_o,
  output logic [31:0] host_rd_data_o,
  output logic        host_rd_valid_o,
  output logic        dev_wr_o,
  output logic        dev_rd_o,
  output logic [3:0]  dev_addr_o,
  output logic [31:0] dev_data_o,
  input  logic [31:0] dev_rd_data_in,
  input  logic        dev_rd_valid_in,
  output logic        seq_rd_valid,
  output logic [31:0] seq_rd_data
);

  logic owner_seq_reg;

  assign host_ready_o = ~seq_own;
  assign dev_wr_o     = seq_own ? seq_wr   : host_wr_in;
  assign dev_rd_o     = seq_own ? seq_rd   : host_rd_in;
  assign dev_addr_o   = seq_own ? seq_addr : host_addr_in;
  assign dev_data_o   = seq_own ? seq_data : host_data_in;

  // Device read latency is fixed at one cycle, so the flag of the last issue
  // always belongs to the return arriving now.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_seq_reg <= 1'b0;
    end else if (dev_rd_o) begin
      owner_seq_reg <= seq_own;
    end
  end

  assign seq_rd_valid    = dev_rd_valid_in & owner_seq_reg;
  assign seq_rd_data     = dev_rd_data_in;
  assign host_rd_valid_o = dev_rd_valid_in & ~owner_seq_reg;
  assign host_rd_data_o  = host_rd_valid_o ? dev_rd_data_in : 32'h0;

endmodule

// File: rtl/g11620_seq.sv
// G11620 frame sequencer: runs a programmed number of frames over a small
// exposure table, polling the CTRL done bit and sharing the register port with the host.
module g11620_seq
  import g11620_pkg::*;
#(
  parameter int NUM_EXP  = 4,
  parameter int POLL_GAP = 16,
  parameter int TIMEOUT  = 1 << 20
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       seq_start_in,
  input  logic                       seq_abort_in,
  input  logic [15:0]                frame_num_in,
  input  logic                       exp_wr_in,
  input  logic [$clog2(NUM_EXP)-1:0] exp_idx_in,
  input  logic [9:0]                 exp_data_in,
  input  logic                       host_wr_in,
  input  logic                       host_rd_in,
  input  logic [3:0]                 host_addr_in,
  input  logic [31:0]                host_data_in,
  output logic                       host_ready_o,
  output logic [31:0]                host_rd_data_o,
  output logic                       host_rd_valid_o,
  output logic                       dev_wr_o,
  output logic                       dev_rd_o,
  output logic [3:0]                 dev_addr_o,
  output logic [31:0]                dev_data_o,
  input  logic [31:0]                dev_rd_data_in,
  input  logic                       dev_rd_valid_in,
  output logic                       start_o,
  output logic [9:0]                 integ_time_o,
  output logic                       busy_o,
  output logic                       frame_done_o,
  output logic [$clog2(NUM_EXP)-1:0] exp_sel_o,
  output logic [15:0]                frames_left_o,
  output logic                       timeout_o
);

  localparam int IDX_W = $clog2(NUM_EXP);
  localparam int GAP_W = $clog2(POLL_GAP + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  seq_state_t        state_reg, state_next;
  logic [9:0]        exp_tab [NUM_EXP];
  logic [IDX_W-1:0]  exp_sel_reg;
  logic [15:0]       frames_left_reg;
  logic [9:0]        integ_reg;
  logic [GAP_W-1:0]  gap_cnt_reg;
  logic [TMO_W-1:0]  tmo_cnt_reg;
  logic [31:0]       cap_reg;
  logic              abort_pend_reg;
  logic              timeout_reg;

  logic              seq_own, seq_wr, seq_rd;
  logic [3:0]        seq_addr;
  logic [31:0]       seq_data;
  logic              seq_rd_valid;
  logic [31:0]       seq_rd_data;
  logic              waiting, tmo_hit, gap_done, done_seen;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_EXP; gi++) begin : g_exp
      always_ff @(posedge clk) begin
        if (rst) begin
          exp_tab[gi] <= 10'd0;
        end else if (exp_wr_in && exp_idx_in == IDX_W'(gi)) begin
          exp_tab[gi] <= exp_data_in;
        end
      end
    end
  endgenerate

  assign waiting   = (state_reg == S_GAP) || (state_reg == S_POLL) || (state_reg == S_PWAIT);
  assign tmo_hit   = waiting && (tmo_cnt_reg == TMO_W'(TIMEOUT - 1));
  assign gap_done  = (gap_cnt_reg == GAP_W'(POLL_GAP - 1));
  assign done_seen = seq_rd_valid && seq_rd_data[CTRL_DONE_BIT];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    seq_own    = 1'b0;
    seq_wr     = 1'b0;
    seq_rd     = 1'b0;
    seq_addr   = ADDR_CTRL;
    seq_data   = 32'h0;
    case (state_reg)
      S_IDLE:  if (seq_start_in) state_next = S_LOAD;
      S_LOAD: begin
        seq_own    = 1'b1;
        seq_wr     = 1'b1;
        seq_addr   = ADDR_INTEG;
        seq_data   = {22'h0, exp_tab[exp_sel_reg]};
        state_next = S_START;
      end
      S_START: state_next = S_GAP;
      S_GAP:   if (gap_done) state_next = S_POLL;
      S_POLL: begin
        seq_own    = 1'b1;
        seq_rd     = 1'b1;
        state_next = S_PWAIT;
      end
      S_PWAIT: begin
        seq_own = 1'b1;
        if (seq_rd_valid) state_next = done_seen ? S_CLEAR : S_GAP;
      end
      S_CLEAR: begin
        seq_own    = 1'b1;
        seq_wr     = 1'b1;
        seq_data   = ctrl_ack(cap_reg);
        state_next = S_NEXT;
      end
      S_NEXT:  state_next = (frames_left_reg == 16'd1) ? S_IDLE : S_LOAD;
      S_ABORT: begin
        seq_own    = 1'b1;
        seq_wr     = 1'b1;
        seq_data   = CTRL_SRST_WORD;
        state_next = S_ABCLR;
      end
      S_ABCLR: begin
        seq_own    = 1'b1;
        seq_wr     = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    // Abort and timeout override the normal flow once the current cycle's bus op is done.
    if (state_reg != S_IDLE && state_reg != S_ABORT && state_reg != S_ABCLR &&
        (abort_pend_reg || seq_abort_in || tmo_hit)) begin
      state_next = S_ABORT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exp_sel_reg     <= '0;
      frames_left_reg <= 16'd0;
      integ_reg       <= 10'd0;
      gap_cnt_reg     <= '0;
      tmo_cnt_reg     <= '0;
      cap_reg         <= 32'h0;
      abort_pend_reg  <= 1'b0;
      timeout_reg     <= 1'b0;
    end else begin
      if (state_reg == S_IDLE || state_reg == S_ABORT || state_reg == S_ABCLR) begin
        abort_pend_reg <= 1'b0;
      end else if (seq_abort_in) begin
        abort_pend_reg <= 1'b1;
      end
      gap_cnt_reg <= (state_reg == S_GAP) ? gap_cnt_reg + 1'b1 : '0;
      if (state_reg == S_START) begin
        tmo_cnt_reg <= '0;
      end else if (waiting) begin
        tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
      end
      if (tmo_hit) timeout_reg <= 1'b1;
      if (state_reg == S_IDLE && seq_start_in) begin
        frames_left_reg <= (frame_num_in == 16'd0) ? 16'd1 : frame_num_in;
        exp_sel_reg     <= '0;
        timeout_reg     <= 1'b0;
      end
      if (state_reg == S_LOAD) integ_reg <= exp_tab[exp_sel_reg];
      if (state_reg == S_PWAIT && done_seen) cap_reg <= seq_rd_data;
      if (state_reg == S_NEXT && state_next != S_ABORT) begin
        frames_left_reg <= frames_left_reg - 16'd1;
        exp_sel_reg     <= exp_sel_reg + 1'b1;
      end
    end
  end

  g11620_bus_arb u_arb (
    .clk             (clk),
    .rst             (rst),
    .seq_own         (seq_own),
    .seq_wr          (seq_wr),
    .seq_rd          (seq_rd),
    .seq_addr        (seq_addr),
    .seq_data        (seq_data),
    .host_wr_in      (host_wr_in),
    .host_rd_in      (host_rd_in),
    .host_addr_in    (host_addr_in),
    .host_data_in    (host_data_in),
    .host_ready_o    (host_ready_o),
    .host_rd_data_o  (host_rd_data_o),
    .host_rd_valid_o (host_rd_valid_o),
    .dev_wr_o        (dev_wr_o),
    .dev_rd_o        (dev_rd_o),
    .dev_addr_o      (dev_addr_o),
    .dev_data_o      (dev_data_o),
    .dev_rd_data_in  (dev_rd_data_in),
    .dev_rd_valid_in (dev_rd_valid_in),
    .seq_rd_valid    (seq_rd_valid),
    .seq_rd_data     (seq_rd_data)
  );

  assign start_o       = (state_reg == S_START);
  assign frame_done_o  = (state_reg == S_CLEAR);
  assign busy_o        = (state_reg != S_IDLE);
  assign integ_time_o  = integ_reg;
  assign exp_sel_o     = exp_sel_reg;
  assign frames_left_o = frames_left_reg;
  assign timeout_o     = timeout_reg;

endmodule

// File: tb/tb_g11620_seq.sv
// Directed bench for g11620_seq with a small behavioural G11620 register model.
module tb_g11620_seq;

  localparam int NUM_EXP  = 4;
  localparam int POLL_GAP = 16;
  localparam int TIMEOUT  = 200;
  localparam int DONE_DLY = 50;

  logic        clk = 1'b0;
  logic        rst;
  logic        seq_start_in, seq_abort_in;
  logic [15:0] frame_num_in;
  logic        exp_wr_in;
  logic [1:0]  exp_idx_in;
  logic [9:0]  exp_data_in;
  logic        host_wr_in, host_rd_in;
  logic [3:0]  host_addr_in;
  logic [31:0] host_data_in;
  logic        host_ready_o;
  logic [31:0] host_rd_data_o;
  logic        host_rd_valid_o;
  logic        dev_wr_o, dev_rd_o;
  logic [3:0]  dev_addr_o;
  logic [31:0] dev_data_o;
  logic [31:0] dev_rd_data_in = 32'h0;
  logic        dev_rd_valid_in = 1'b0;
  logic        start_o;
  logic [9:0]  integ_time_o;
  logic        busy_o, frame_done_o;
  logic [1:0]  exp_sel_o;
  logic [15:0] frames_left_o;
  logic        timeout_o;

  int checks = 0;
  int errors = 0;

  // Sensor controller model and transaction logs
  logic [31:0] s_ctrl = 32'h0000_0020;
  logic [9:0]  s_integ = 10'd0;
  int          done_cnt = 0;
  bit          done_en = 1'b1;
  int          done_total = 0;
  logic [9:0]  integ_q[$];
  logic [31:0] ctrl_q[$];

  always #5 clk = ~clk;

  g11620_seq #(.NUM_EXP(NUM_EXP), .POLL_GAP(POLL_GAP), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .seq_start_in(seq_start_in), .seq_abort_in(seq_abort_in), .frame_num_in(frame_num_in),
    .exp_wr_in(exp_wr_in), .exp_idx_in(exp_idx_in), .exp_data_in(exp_data_in),
    .host_wr_in(host_wr_in), .host_rd_in(host_rd_in), .host_addr_in(host_addr_in),
    .host_data_in(host_data_in), .host_ready_o(host_ready_o), .host_rd_data_o(host_rd_data_o),
    .host_rd_valid_o(host_rd_valid_o), .dev_wr_o(dev_wr_o), .dev_rd_o(dev_rd_o),
    .dev_addr_o(dev_addr_o), .dev_data_o(dev_data_o), .dev_rd_data_in(dev_rd_data_in),
    .dev_rd_valid_in(dev_rd_valid_in), .start_o(start_o), .integ_time_o(integ_time_o),
    .busy_o(busy_o), .frame_done_o(frame_done_o), .exp_sel_o(exp_sel_o),
    .frames_left_o(frames_left_o), .timeout_o(timeout_o)
  );

  always @(posedge clk) begin
    dev_rd_valid_in <= dev_rd_o;
    dev_rd_data_in  <= !dev_rd_o ? 32'h0 : (dev_addr_o == 4'd1) ? {22'h0, s_integ} : s_ctrl;
    if (dev_wr_o && dev_addr_o == 4'd0) begin
      s_ctrl <= dev_data_o;
      ctrl_q.push_back(dev_data_o);
      if (dev_data_o[29]) done_cnt <= 0;
    end else if (start_o) begin
      done_cnt <= DONE_DLY;
    end else if (done_cnt > 0) begin
      done_cnt <= done_cnt - 1;
      if (done_cnt == 1 && done_en) s_ctrl[30] <= 1'b1;
    end
    if (dev_wr_o && dev_addr_o == 4'd1) s_integ <= dev_data_o[9:0];
    if (start_o) integ_q.push_back(integ_time_o);
    if (frame_done_o) done_total <= done_total + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%08h", tag, got);
    end
  endtask

  // Returns at the negedge of the LOAD cycle.
  task automatic start_seq(input logic [15:0] n);
    @(negedge clk);
    frame_num_in = n;
    seq_start_in = 1'b1;
    @(negedge clk);
    seq_start_in = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, input string tag);
    int n;
    n = 0;
    while (busy_o && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'h0, busy_o}, 32'h0);
  endtask

  initial begin
    int d0, base, n;
    logic [9:0]  tab [4];
    logic [31:0] w;
    tab[0] = 10'd10; tab[1] = 10'd20; tab[2] = 10'd30; tab[3] = 10'd40;
    rst = 1'b1; seq_start_in = 1'b0; seq_abort_in = 1'b0; frame_num_in = 16'd0;
    exp_wr_in = 1'b0; exp_idx_in = 2'd0; exp_data_in = 10'd0;
    host_wr_in = 1'b0; host_rd_in = 1'b0; host_addr_in = 4'd0; host_data_in = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_dev_wr", {31'h0, dev_wr_o}, 0);
    chk("rst_dev_rd", {31'h0, dev_rd_o}, 0);
    chk("rst_host_ready", {31'h0, host_ready_o}, 1);
    chk("rst_busy", {31'h0, busy_o}, 0);
    chk("rst_start", {31'h0, start_o}, 0);
    chk("rst_integ", {22'h0, integ_time_o}, 0);
    chk("rst_frames_left", {16'h0, frames_left_o}, 0);
    chk("rst_flags", {28'h0, timeout_o, frame_done_o, host_rd_valid_o, 1'b0}, 0);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      exp_wr_in = 1'b1; exp_idx_in = 2'(i); exp_data_in = tab[i];
    end
    @(negedge clk);
    exp_wr_in = 1'b0;

    // Three frames over the table
    d0 = done_total; base = integ_q.size();
    start_seq(16'd3);
    chk("load_wr", {31'h0, dev_wr_o}, 1);
    chk("load_addr", {28'h0, dev_addr_o}, 1);
    chk("load_data", dev_data_o, 32'd10);
    chk("load_host_ready", {31'h0, host_ready_o}, 0);
    chk("load_frames_left", {16'h0, frames_left_o}, 3);
    @(negedge clk);
    chk("start_pulse", {31'h0, start_o}, 1);
    chk("start_integ", {22'h0, integ_time_o}, 10);
    @(negedge clk);
    chk("start_one_cycle", {31'h0, start_o}, 0);
    wait_idle(2000, "run3_idle");
    chk("run3_done_pulses", done_total - d0, 3);
    for (int i = 0; i < 3; i++) begin
      w = (integ_q.size() > base + i) ? {22'h0, integ_q[base + i]} : 32'hFFFF_FFFF;
      chk($sformatf("run3_integ%0d", i), w, {22'h0, tab[i]});
    end
    chk("run3_exp_sel", {30'h0, exp_sel_o}, 3);
    chk("run3_frames_left", {16'h0, frames_left_o}, 0);
    w = (ctrl_q.size() > 0) ? ctrl_q[ctrl_q.size() - 1] : 32'hFFFF_FFFF;
    chk("run3_ctrl_ack", w, 32'h0000_0020);

    // Zero frames behaves as one
    d0 = done_total; base = integ_q.size();
    start_seq(16'd0);
    chk("zero_frames_left", {16'h0, frames_left_o}, 1);
    wait_idle(500, "zero_idle");
    chk("zero_done_pulses", done_total - d0, 1);
    chk("zero_starts", integ_q.size() - base, 1);

    // Host read of INTEG while the sequencer sits in GAP
    d0 = done_total;
    start_seq(16'd1);
    repeat (4) @(negedge clk);
    host_rd_in = 1'b1; host_addr_in = 4'd1;
    #1;
    chk("hrd_ready", {31'h0, host_ready_o}, 1);
    chk("hrd_dev_rd", {27'h0, dev_rd_o, dev_addr_o}, 32'h11);
    @(negedge clk);
    host_rd_in = 1'b0;
    chk("hrd_valid", {31'h0, host_rd_valid_o}, 1);
    chk("hrd_data", host_rd_data_o, 32'd10);
    #1;
    chk("hrd_seq_in_gap", {30'h0, host_ready_o, busy_o}, 32'h3);
    wait_idle(500, "hrd_idle");
    chk("hrd_frame_done", done_total - d0, 1);

    // Host write held across POLL/PWAIT
    start_seq(16'd1);
    n = 0;
    while (!(dev_rd_o && !host_ready_o) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("hwr_found_poll", {31'h0, dev_rd_o}, 1);
    host_wr_in = 1'b1; host_addr_in = 4'd1; host_data_in = 32'h155;
    #1;
    chk("hwr_poll_ready", {30'h0, host_ready_o, dev_wr_o}, 0);
    @(negedge clk);
    chk("hwr_pwait_ready", {30'h0, host_ready_o, dev_wr_o}, 0);
    @(negedge clk);
    chk("hwr_gap_ready", {30'h0, host_ready_o, dev_wr_o}, 32'h3);
    chk("hwr_gap_bus", {dev_addr_o, dev_data_o[27:0]}, 32'h1000_0155);
    @(negedge clk);
    host_wr_in = 1'b0;
    chk("hwr_sensor_integ", {22'h0, s_integ}, 32'h155);
    wait_idle(500, "hwr_idle");

    // Done never arrives: timeout abort
    done_en = 1'b0;
    d0 = done_total;
    ctrl_q.delete();
    start_seq(16'd2);
    wait_idle(600, "tmo_idle");
    chk("tmo_flag", {31'h0, timeout_o}, 1);
    chk("tmo_ctrl_writes", ctrl_q.size(), 2);
    w = (ctrl_q.size() > 0) ? ctrl_q[0] : 32'hFFFF_FFFF;
    chk("tmo_ctrl_srst", w, 32'h2000_0000);
    w = (ctrl_q.size() > 1) ? ctrl_q[1] : 32'hFFFF_FFFF;
    chk("tmo_ctrl_zero", w, 32'h0);
    chk("tmo_no_done", done_total - d0, 0);
    chk("tmo_host_ready", {31'h0, host_ready_o}, 1);

    // Abort mid-GAP on frame 2 of 5, then a clean restart
    done_en = 1'b1;
    base = integ_q.size();
    start_seq(16'd5);
    chk("abt_tmo_cleared", {31'h0, timeout_o}, 0);
    n = 0;
    while (integ_q.size() < base + 2 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("abt_frame2_started", integ_q.size() - base, 2);
    repeat (5) @(negedge clk);
    chk("abt_in_gap", {30'h0, host_ready_o, busy_o}, 32'h3);
    ctrl_q.delete();
    seq_abort_in = 1'b1;
    @(negedge clk);
    seq_abort_in = 1'b0;
    wait_idle(50, "abt_idle");
    chk("abt_ctrl_writes", ctrl_q.size(), 2);
    w = (ctrl_q.size() > 0) ? ctrl_q[0] : 32'hFFFF_FFFF;
    chk("abt_ctrl_srst", w, 32'h2000_0000);
    w = (ctrl_q.size() > 1) ? ctrl_q[1] : 32'hFFFF_FFFF;
    chk("abt_ctrl_zero", w, 32'h0);
    chk("abt_frames_left", {16'h0, frames_left_o}, 4);
    chk("abt_no_timeout", {31'h0, timeout_o}, 0);

    d0 = done_total; base = integ_q.size();
    start_seq(16'd1);
    wait_idle(500, "restart_idle");
    chk("restart_done", done_total - d0, 1);
    w = (integ_q.size() > base) ? {22'h0, integ_q[base]} : 32'hFFFF_FFFF;
    chk("restart_integ", w, 32'd10);
    chk("restart_exp_sel", {30'h0, exp_sel_o}, 1);
    chk("restart_frames_left", {16'h0, frames_left_o}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
